// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: 2:1 round-robin AXI4 read arbiter (AR+R), one outstanding burst; optional AXI4_RD_ARB_BEAT_CHECK_EN adds ERR_RLAST
module axi4_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [2*ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [15:0]             S_ARLEN,
  input  logic [5:0]              S_ARSIZE,
  input  logic [3:0]              S_ARBURST,
  input  logic [1:0]              S_ARVALID,
  output logic [1:0]              S_ARREADY,
  output logic [2*DATA_WIDTH-1:0] S_RDATA,
  output logic [3:0]              S_RRESP,
  output logic [1:0]              S_RLAST,
  output logic [1:0]              S_RVALID,
  input  logic [1:0]              S_RREADY,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RLAST,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
`ifdef AXI4_RD_ARB_BEAT_CHECK_EN
  ,
  output logic                    ERR_RLAST
`endif
);
  typedef enum logic [1:0] {IDLE, AR_FWD, R_FWD} state_t;
  state_t state, state_n;
  logic g, g_n, lg, lg_n, ar, r;
  assign ar = state == AR_FWD;
  assign r  = state == R_FWD;
  // state, grant and last-served registers; lg=1 lets master 0 win the first tie
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
      g     <= 1'b0;
      lg    <= 1'b1;
    end else begin
      state <= state_n;
      g     <= g_n;
      lg    <= lg_n;
    end
  end
  // arbitration in IDLE, AR handshake exit, RLAST handshake exit
  always_comb begin
    state_n = state;
    g_n     = g;
    lg_n    = lg;
    if (state == IDLE && |S_ARVALID) begin
      g_n     = &S_ARVALID ? ~lg : S_ARVALID[1];
      state_n = AR_FWD;
    end else if (ar && M_ARVALID && M_ARREADY) begin
      state_n = R_FWD;
    end else if (r && M_RVALID && M_RREADY && M_RLAST) begin
      lg_n    = g;
      state_n = IDLE;
    end
  end
  // route the granted master's AR to the slave and the slave's R back to it
  always_comb begin
    M_ARADDR   = ar ? (g ? S_ARADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : S_ARADDR[ADDR_WIDTH-1:0]) : '0;
    M_ARLEN    = ar ? (g ? S_ARLEN[15:8] : S_ARLEN[7:0]) : '0;
    M_ARSIZE   = ar ? (g ? S_ARSIZE[5:3] : S_ARSIZE[2:0]) : '0;
    M_ARBURST  = ar ? (g ? S_ARBURST[3:2] : S_ARBURST[1:0]) : '0;
    M_ARVALID  = ar & S_ARVALID[g];
    M_RREADY   = r & S_RREADY[g];
    S_ARREADY  = '0;
    S_RVALID   = '0;
    S_RLAST    = '0;
    S_RDATA    = '0;
    S_RRESP    = '0;
    S_ARREADY[g] = ar & M_ARREADY;
    S_RVALID[g]  = r & M_RVALID;
    S_RLAST[g]   = r & M_RLAST;
    if (r && g) begin
      S_RDATA[2*DATA_WIDTH-1:DATA_WIDTH] = M_RDATA;
      S_RRESP[3:2] = M_RRESP;
    end else if (r) begin
      S_RDATA[DATA_WIDTH-1:0] = M_RDATA;
      S_RRESP[1:0] = M_RRESP;
    end
  end
`ifdef AXI4_RD_ARB_BEAT_CHECK_EN
  logic [7:0] cnt, len;
  // latch ARLEN at AR handshake, count R beats, flag RLAST/count disagreement for one cycle
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt       <= '0;
      len       <= '0;
      ERR_RLAST <= 1'b0;
    end else begin
      ERR_RLAST <= 1'b0;
      if (M_ARVALID && M_ARREADY) begin
        len <= M_ARLEN;
        cnt <= '0;
      end
      if (M_RREADY && M_RVALID) begin
        cnt       <= cnt + 8'd1;
        ERR_RLAST <= M_RLAST != (cnt == len);
      end
    end
  end
`endif
endmodule
